rs_latch_writer: RTL and testbench
==================================

Name: rs_latch_writer

Overview:
- Synchronous write controller for the team's gated RS latch.
- Accepts a one-bit write request over a valid/ready handshake.
- Drives the latch's S or R input with a timed pulse, waits a settle window, then reads back Q/Qn.
- Reports completion, the read value, and a verify error, with bounded automatic retries.
- Sits between register/control logic and one latch instance in the same clock domain.

Parameters:
- PULSE_W, 2: cycles S_out or R_out is held high per attempt; legal range 1..15.
- SETTLE_W, 1: cycles with S_out=R_out=0 between pulse end and readback; legal range 1..15.
- MAX_RETRY, 1: extra attempts after a failed verify; legal range 0..7.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous active-low reset, sampled on rising Clk
- Wr_valid  input  1  write request
- Wr_data  input  1  value to store in latch (1 = set, 0 = reset)
- Wr_ready  output  1  controller idle, request accepted when Wr_valid & Wr_ready
- S_out  output  1  to latch S input
- R_out  output  1  to latch R input
- Q_in  input  1  from latch Q
- Qn_in  input  1  from latch Qn
- Done  output  1  one-cycle completion pulse
- Err  output  1  valid with Done; 1 = verify failed after all retries
- Rd_q  output  1  Q_in value sampled at final check; held until next Done

Behaviour:
- Reset and outputs:
  - All state and output registers are cleared on a rising Clk edge with Rst_n=0: state=IDLE, S_out=R_out=Done=Err=Rd_q=0, retry count=0.
  - Wr_ready is (state==IDLE) & Rst_n, so it is 0 whenever Rst_n is low.
  - Reset mid-operation abandons the write. No Done is produced. S_out/R_out drop at that edge.
  - S_out and R_out are registered. They are never 1 together, in any state or on reset.
- States: IDLE, PULSE, SETTLE, CHECK.
- IDLE:
  - Wr_ready=1.
  - On accept, Wr_data is captured, the retry count is cleared, and the next state is PULSE.
  - Wr_valid without Wr_ready is ignored; no queuing.
- PULSE:
  - S_out=data (or R_out=~data) for exactly PULSE_W cycles, starting the cycle after accept.
  - Then go to SETTLE.
- SETTLE:
  - S_out=R_out=0 for exactly SETTLE_W cycles.
  - Then go to CHECK.
- CHECK (one cycle):
  - Pass condition: Q_in==data and Qn_in==~data. Q_in==Qn_in is always a fail.
  - Pass: go to IDLE. Done=1, Err=0, Rd_q=Q_in in the following cycle.
  - Fail with retry count < MAX_RETRY: increment the count and go to PULSE. No Done.
  - Fail with retry count == MAX_RETRY: go to IDLE. Done=1, Err=1, Rd_q=Q_in in the following cycle.
- Latency:
  - Accept at cycle 0 gives Done at cycle PULSE_W+SETTLE_W+2.
  - Each retry adds PULSE_W+SETTLE_W+1 cycles.
- Back-to-back: Done and Wr_ready are both 1 in the first IDLE cycle, so a new request may be accepted that same cycle. Done is still a one-cycle pulse.
- Counters:
  - Phase counter is 4 bits, loaded with W-1 and decremented to 0.
  - Retry counter is 3 bits and saturates at MAX_RETRY. No wrap.
- Q_in/Qn_in are used only in CHECK; values in other states are ignored.
- Latch inputs are same-domain and are not synchronized.

Test Plan:
- Set write, defaults, latch model attached, latch initially Q=0:
  - Wr_valid=1, Wr_data=1 accepted at cycle 0 -> S_out=1 in cycles 1-2 and R_out=0 throughout.
  - Cycle 3 has S_out=0 -> Done=1, Err=0, Rd_q=1 at cycle 5.
- Reset write, latch holding Q=1:
  - Wr_data=0 -> R_out=1 in cycles 1-2 -> Done at cycle 5 with Err=0, Rd_q=0.
- Stuck latch, MAX_RETRY=1, Q_in=0/Qn_in=1 forced, Wr_data=1:
  - Pulses appear in cycles 1-2 and 5-6.
  - Done=1, Err=1, Rd_q=0 at cycle 9. Exactly one Done pulse.
- Invalid latch state, Q_in=Qn_in=1 forced, Wr_data=1, MAX_RETRY=0 -> Done at cycle 5 with Err=1, Rd_q=1.
- Handshake:
  - Wr_valid held high with alternating data -> second request accepted in the Done cycle (cycle 5).
  - Second pulse appears in cycles 6-7.
  - Wr_valid during PULSE/SETTLE/CHECK is not accepted, and Wr_ready=0 in those cycles.
- Reset mid-pulse:
  - Rst_n=0 sampled at cycle 2 of a set write -> S_out=0, Wr_ready=0 while low, no Done.
  - After release, Wr_ready=1 and a fresh write completes normally in 5 cycles.

Source files
------------

// File: rtl/rs_latch_writer.sv
// Write controller for a gated RS latch: timed S/R pulse, settle window,
// Q/Qn readback with bounded automatic retries.
module rs_latch_writer #(
    parameter int PULSE_W   = 2,
    parameter int SETTLE_W  = 1,
    parameter int MAX_RETRY = 1
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Wr_valid,
    input  logic Wr_data,
    output logic Wr_ready,
    output logic S_out,
    output logic R_out,
    input  logic Q_in,
    input  logic Qn_in,
    output logic Done,
    output logic Err,
    output logic Rd_q
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] retry;
    logic       data;
    logic       accept;
    logic       pass;

    assign Wr_ready = (state == IDLE) & Rst_n;
    assign accept   = Wr_valid & Wr_ready;
    // Q_in==Qn_in can never match data/~data, so an invalid latch state always fails.
    assign pass     = (Q_in == data) && (Qn_in == ~data);

    // Captured write value is datapath only and needs no reset.
    always_ff @(posedge Clk) begin
        if (accept) begin
            data <= Wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            retry <= 3'd0;
            S_out <= 1'b0;
            R_out <= 1'b0;
            Done  <= 1'b0;
            Err   <= 1'b0;
            Rd_q  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Wr_valid) begin
                        retry <= 3'd0;
                        cnt   <= 4'(PULSE_W - 1);
                        S_out <= Wr_data;
                        R_out <= ~Wr_data;
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == 4'd0) begin
                        S_out <= 1'b0;
                        R_out <= 1'b0;
                        cnt   <= 4'(SETTLE_W - 1);
                        state <= SETTLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (pass) begin
                        Done  <= 1'b1;
                        Err   <= 1'b0;
                        Rd_q  <= Q_in;
                        state <= IDLE;
                    end else if (retry < 3'(MAX_RETRY)) begin
                        retry <= retry + 3'd1;
                        cnt   <= 4'(PULSE_W - 1);
                        S_out <= data;
                        R_out <= ~data;
                        state <= PULSE;
                    end else begin
                        Done  <= 1'b1;
                        Err   <= 1'b1;
                        Rd_q  <= Q_in;
                        state <= IDLE;
                    end
                end
                default: begin
                    S_out <= 1'b0;
                    R_out <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_latch_writer.sv
// Scoreboard bench for rs_latch_writer: latch model, stuck/invalid latch
// cases, back-to-back handshake and mid-pulse reset.
module tb_rs_latch_writer;

    logic Clk = 1'b0;
    logic Rst_n;
    logic Wr_valid, Wr_data, Wr_ready;
    logic S_out, R_out, Q_in, Qn_in, Done, Err, Rd_q;

    logic v0, d0, rdy0, s0, r0, done0, err0, rdq0;

    logic lq = 1'b0;
    int   mode;
    int   cyc = 0;
    int   n_tests;
    int   n_fail;

    typedef struct {
        int   cyc;
        logic err;
        logic rdq;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Simple latch model; mode 1 = stuck at 0, mode 2 = invalid Q=Qn=1
    always @(posedge Clk) begin
        if (S_out) lq <= 1'b1;
        else if (R_out) lq <= 1'b0;
    end
    assign Q_in  = (mode == 0) ? lq  : (mode == 2);
    assign Qn_in = (mode == 0) ? ~lq : 1'b1;

    rs_latch_writer dut (
        .Clk(Clk), .Rst_n(Rst_n), .Wr_valid(Wr_valid), .Wr_data(Wr_data),
        .Wr_ready(Wr_ready), .S_out(S_out), .R_out(R_out), .Q_in(Q_in),
        .Qn_in(Qn_in), .Done(Done), .Err(Err), .Rd_q(Rd_q)
    );

    rs_latch_writer #(.PULSE_W(2), .SETTLE_W(1), .MAX_RETRY(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Wr_valid(v0), .Wr_data(d0),
        .Wr_ready(rdy0), .S_out(s0), .R_out(r0), .Q_in(1'b1),
        .Qn_in(1'b1), .Done(done0), .Err(err0), .Rd_q(rdq0)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    // Returns at the negedge of the cycle after acceptance.
    task automatic do_write(input logic d, input logic e, input logic rq,
                            input int retries, input bit push);
        int n;
        n = 0;
        step();
        while (!Wr_ready && n < 50) begin
            step();
            n++;
        end
        if (!Wr_ready) check("ready_timeout", Wr_ready, 1);
        Wr_valid = 1'b1;
        Wr_data  = d;
        if (push) sb.push_back('{cyc + 5 + 4 * retries, e, rq});
        step();
        Wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge Clk) begin
        if (Rst_n) check("excl", int'(S_out & R_out), 0);
        if (Done) begin
            check("done_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("err", Err, e.err);
                check("rd_q", Rd_q, e.rdq);
            end
        end
    end

    initial begin
        int c0;
        n_tests  = 0;
        n_fail   = 0;
        mode     = 0;
        Rst_n    = 1'b0;
        Wr_valid = 1'b0;
        Wr_data  = 1'b0;
        v0       = 1'b0;
        d0       = 1'b0;
        repeat (3) step();
        check("rst_s", S_out, 0);
        check("rst_r", R_out, 0);
        check("rst_done", Done, 0);
        check("rst_err", Err, 0);
        check("rst_rdq", Rd_q, 0);
        check("rst_ready", Wr_ready, 0);
        Rst_n = 1'b1;
        step();
        check("idle_ready", Wr_ready, 1);

        // Set write, latch starts at Q=0
        do_write(1'b1, 1'b0, 1'b1, 0, 1'b1);
        check("set_s1", S_out, 1);
        check("set_r1", R_out, 0);
        check("set_busy1", Wr_ready, 0);
        step();
        check("set_s2", S_out, 1);
        step();
        check("set_s3", S_out, 0);
        check("set_r3", R_out, 0);
        wait_idle();

        // Reset write, latch now holds Q=1
        do_write(1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("clr_r1", R_out, 1);
        check("clr_s1", S_out, 0);
        step();
        check("clr_r2", R_out, 1);
        step();
        check("clr_r3", R_out, 0);
        wait_idle();

        // Stuck latch, one retry
        mode = 1;
        do_write(1'b1, 1'b1, 1'b0, 1, 1'b1);
        check("stk_s1", S_out, 1);
        step();
        check("stk_s2", S_out, 1);
        step();
        check("stk_s3", S_out, 0);
        step();
        check("stk_s4", S_out, 0);
        step();
        check("stk_s5", S_out, 1);
        step();
        check("stk_s6", S_out, 1);
        step();
        check("stk_s7", S_out, 0);
        wait_idle();
        repeat (3) step();
        mode = 0;

        // Back-to-back with Wr_valid held high, latch holds Q=1
        step();
        c0 = cyc;
        Wr_valid = 1'b1;
        Wr_data  = 1'b0;
        sb.push_back('{c0 + 5, 1'b0, 1'b0});
        for (int k = 1; k <= 4; k++) begin
            step();
            Wr_data = k[0];
            check("hs_busy", Wr_ready, 0);
        end
        step();
        check("hs_ready_done", Wr_ready, 1);
        check("hs_done", Done, 1);
        Wr_data = 1'b1;
        sb.push_back('{c0 + 10, 1'b0, 1'b1});
        step();
        Wr_valid = 1'b0;
        check("hs_s6", S_out, 1);
        check("hs_done_pulse", Done, 0);
        step();
        check("hs_s7", S_out, 1);
        wait_idle();

        // Reset mid-pulse
        do_write(1'b1, 1'b0, 1'b1, 0, 1'b0);
        check("rp_s1", S_out, 1);
        Rst_n = 1'b0;
        step();
        check("rp_s_off", S_out, 0);
        check("rp_ready", Wr_ready, 0);
        check("rp_done", Done, 0);
        step();
        check("rp_ready2", Wr_ready, 0);
        Rst_n = 1'b1;
        step();
        check("rp_ready_rel", Wr_ready, 1);
        repeat (6) step();
        do_write(1'b0, 1'b0, 1'b0, 0, 1'b1);
        wait_idle();

        // Invalid latch state Q=Qn=1, no retries
        step();
        v0 = 1'b1;
        d0 = 1'b1;
        step();
        v0 = 1'b0;
        check("inv_s1", s0, 1);
        repeat (3) step();
        check("inv_done4", done0, 0);
        step();
        check("inv_done5", done0, 1);
        check("inv_err", err0, 1);
        check("inv_rdq", rdq0, 1);
        step();
        check("inv_done6", done0, 0);

        repeat (3) step();
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
